// File: rtl/game_board_ctl.sv
// game_board_ctl -- Sudoku board owner and game sequencer.
//
// Holds the 16x16 board (5-bit cell codes, EMPTY = no digit) and the clue
// mask. A new game wipes every cell, loads clues, then accepts player
// commands. Each SET is validated by a sequential scan over its row, its
// column and its box (one step of each per cycle) before the cell is written.
// A completely filled board means the puzzle is solved.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   start_game, board_size_in    new-game pulse and requested box size N
//   clue_valid/x/y/digit, clue_done   clue load interface (LOAD only)
//   cmd_valid, cmd_op, cmd_digit player commands (PLAY only)
//   cmd_ready                    high in PLAY
//   board, fixed                 cell codes [row][col] and clue mask
//   board_size, is_game_on       latched N, game-in-progress flag
//   cursor_x, cursor_y           cursor position
//   move_accepted, move_rejected one-cycle command result pulses
//   filled_count, game_won       non-empty cell count, solved flag
module game_board_ctl #(
  parameter logic [4:0] EMPTY        = 5'd31,
  parameter logic [2:0] DEFAULT_SIZE = 3'd3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_game,
  input  logic [2:0]             board_size_in,
  input  logic                   clue_valid,
  input  logic [3:0]             clue_x,
  input  logic [3:0]             clue_y,
  input  logic [4:0]             clue_digit,
  input  logic                   clue_done,
  input  logic                   cmd_valid,
  input  logic [2:0]             cmd_op,
  input  logic [4:0]             cmd_digit,
  output logic                   cmd_ready,
  output logic [15:0][15:0][4:0] board,
  output logic [15:0][15:0]      fixed,
  output logic [2:0]             board_size,
  output logic                   is_game_on,
  output logic [3:0]             cursor_x,
  output logic [3:0]             cursor_y,
  output logic                   move_accepted,
  output logic                   move_rejected,
  output logic [8:0]             filled_count,
  output logic                   game_won
);

  typedef enum logic [2:0] {IDLE, WIPE, LOAD, PLAY, CHECK, WON} state_t;

  localparam logic [2:0] OP_UP = 3'd1, OP_DOWN = 3'd2, OP_LEFT = 3'd3,
                         OP_RIGHT = 3'd4, OP_SET = 3'd5, OP_CLEAR = 3'd6,
                         OP_NEW = 3'd7;

  state_t                   state_q;
  logic [15:0][15:0][4:0]   board_q;
  logic [15:0][15:0]        fixed_q;
  logic [2:0]               n_q;
  logic [7:0]               idx_q;
  logic [3:0]               cx_q, cy_q;
  logic [3:0]               k_q, r_q, c_q, bx_q, by_q;
  logic [4:0]               dig_q;
  logic [8:0]               filled_q;
  logic                     acc_q, rej_q;

  // Largest multiple of n not above v: box origin without a divider.
  function automatic logic [3:0] box_org(input logic [3:0] v, input logic [2:0] n);
    logic [3:0] o;
    logic [5:0] m;
    o = '0;
    for (int i = 1; i < 16; i++) begin
      m = 6'(i) * 6'(n);
      if (m <= 6'(v)) o = m[3:0];
    end
    return o;
  endfunction

  logic [4:0] s_sz;
  logic [3:0] s_max, n_m1;
  logic [8:0] s_cells, filled_nx;
  logic       size_ok, clue_ok, cur_empty, cur_fixed;
  logic [3:0] br, bc;
  logic       row_hit, col_hit, box_hit;

  always_comb begin
    s_sz      = 5'(n_q) * 5'(n_q);
    s_max     = 4'(s_sz - 5'd1);
    n_m1      = 4'(n_q) - 4'd1;
    s_cells   = 9'(s_sz) * 9'(s_sz);
    size_ok   = (board_size_in >= 3'd2) && (board_size_in <= 3'd4);
    clue_ok   = ({1'b0, clue_x} < s_sz) && ({1'b0, clue_y} < s_sz) && (clue_digit < s_sz);
    cur_empty = (board_q[cy_q][cx_q] == EMPTY);
    cur_fixed = fixed_q[cy_q][cx_q];
    filled_nx = filled_q + {8'd0, cur_empty};
    br        = by_q + r_q;
    bc        = bx_q + c_q;
    // The cursor cell itself is excluded so re-entering its digit is legal.
    row_hit   = (k_q != cx_q) && (board_q[cy_q][k_q] == dig_q);
    col_hit   = (k_q != cy_q) && (board_q[k_q][cx_q] == dig_q);
    box_hit   = !((br == cy_q) && (bc == cx_q)) && (board_q[br][bc] == dig_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      board_q  <= {256{EMPTY}};
      fixed_q  <= '0;
      n_q      <= DEFAULT_SIZE;
      idx_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      k_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      dig_q    <= '0;
      filled_q <= '0;
      acc_q    <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      acc_q <= 1'b0;
      rej_q <= 1'b0;
      // A new game overrides everything, including an in-flight check.
      if (start_game || (state_q == PLAY && cmd_valid && cmd_op == OP_NEW)) begin
        if (start_game) n_q <= size_ok ? board_size_in : DEFAULT_SIZE;
        state_q <= WIPE;
        idx_q   <= '0;
      end else begin
        case (state_q)
          IDLE: ;
          WIPE: begin
            board_q[idx_q[7:4]][idx_q[3:0]] <= EMPTY;
            fixed_q[idx_q[7:4]][idx_q[3:0]] <= 1'b0;
            filled_q <= '0;
            idx_q    <= idx_q + 8'd1;
            if (idx_q == 8'd255) state_q <= LOAD;
          end
          LOAD: begin
            if (clue_valid && clue_ok) begin
              board_q[clue_y][clue_x] <= clue_digit;
              fixed_q[clue_y][clue_x] <= 1'b1;
              if (board_q[clue_y][clue_x] == EMPTY) filled_q <= filled_q + 9'd1;
            end
            if (clue_done) begin
              cx_q    <= '0;
              cy_q    <= '0;
              state_q <= PLAY;
            end
          end
          PLAY: begin
            if (cmd_valid) begin
              case (cmd_op)
                OP_UP:    cy_q <= (cy_q == 4'd0)  ? s_max : cy_q - 4'd1;
                OP_DOWN:  cy_q <= (cy_q == s_max) ? 4'd0  : cy_q + 4'd1;
                OP_LEFT:  cx_q <= (cx_q == 4'd0)  ? s_max : cx_q - 4'd1;
                OP_RIGHT: cx_q <= (cx_q == s_max) ? 4'd0  : cx_q + 4'd1;
                OP_SET: begin
                  if (cmd_digit >= s_sz || cur_fixed) begin
                    rej_q <= 1'b1;
                  end else begin
                    dig_q   <= cmd_digit;
                    k_q     <= '0;
                    r_q     <= '0;
                    c_q     <= '0;
                    bx_q    <= box_org(cx_q, n_q);
                    by_q    <= box_org(cy_q, n_q);
                    state_q <= CHECK;
                  end
                end
                OP_CLEAR: begin
                  if (!cur_fixed && !cur_empty) begin
                    board_q[cy_q][cx_q] <= EMPTY;
                    filled_q <= filled_q - 9'd1;
                    acc_q    <= 1'b1;
                  end else begin
                    rej_q <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
          CHECK: begin
            if (row_hit || col_hit || box_hit) begin
              rej_q   <= 1'b1;
              state_q <= PLAY;
            end else if (k_q == s_max) begin
              board_q[cy_q][cx_q] <= dig_q;
              filled_q <= filled_nx;
              acc_q    <= 1'b1;
              state_q  <= (filled_nx == s_cells) ? WON : PLAY;
            end else begin
              k_q <= k_q + 4'd1;
              // Box walk: column sub-counter first, then next box row.
              if (c_q == n_m1) begin
                c_q <= '0;
                r_q <= r_q + 4'd1;
              end else begin
                c_q <= c_q + 4'd1;
              end
            end
          end
          WON: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign board         = board_q;
  assign fixed         = fixed_q;
  assign board_size    = n_q;
  assign cursor_x      = cx_q;
  assign cursor_y      = cy_q;
  assign filled_count  = filled_q;
  assign move_accepted = acc_q;
  assign move_rejected = rej_q;
  assign cmd_ready     = (state_q == PLAY);
  assign game_won      = (state_q == WON);
  assign is_game_on    = (state_q == LOAD) || (state_q == PLAY) ||
                         (state_q == CHECK) || (state_q == WON);

endmodule
